// File: rtl/fp_addsub_arbiter.sv
// Two-requester round-robin front end sharing one combinational IEEE-754 single adder/subtractor.
// One operation in flight at a time; results and flags are registered and held until consumed.

module fp_add_sub #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] opd1_i,
   input  logic [DATA_W-1:0] opd2_i,
   input  logic              op_i,
   output logic [DATA_W-1:0] res_o,
   output logic [3:0]        flags_o
);
   // Subnormal inputs and results are flushed to zero; rounding is to nearest, ties to even.
   logic        sa, sb, sx, sy, swap, inc;
   logic [7:0]  ea, eb, ex, ey, d;
   logic [22:0] ma, mb, mant;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [23:0] mx, my;
   logic [49:0] shifted;
   logic [26:0] aln_y, norm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [24:0] rnd;
   logic signed [9:0] e_norm, e_fin;

   assign sa = opd1_i[31];
   assign sb = opd2_i[31] ^ op_i;
   assign ea = opd1_i[30:23];
   assign eb = opd2_i[30:23];
   assign ma = opd1_i[22:0];
   assign mb = opd2_i[22:0];

   assign a_nan  = (ea == 8'hFF) && (ma != '0);
   assign b_nan  = (eb == 8'hFF) && (mb != '0);
   assign a_inf  = (ea == 8'hFF) && (ma == '0);
   assign b_inf  = (eb == 8'hFF) && (mb == '0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);

   // x is the larger magnitude, so the effective subtraction never goes negative.
   assign swap = {eb, mb} > {ea, ma};
   assign {sx, ex, mx} = swap ? {sb, eb, ~b_zero, mb} : {sa, ea, ~a_zero, ma};
   assign {sy, ey, my} = swap ? {sa, ea, ~a_zero, ma} : {sb, eb, ~b_zero, mb};

   assign d       = ex - ey;
   assign shifted = {my, 26'd0} >> d;
   assign aln_y   = (d > 8'd26) ? {26'd0, |my}
                                : {shifted[49:24], shifted[23] | (|shifted[22:0])};
   assign sum     = (sx == sy) ? {1'b0, mx, 3'd0} + {1'b0, aln_y}
                               : {1'b0, mx, 3'd0} - {1'b0, aln_y};

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      lz = '0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
   end

   always_comb begin
      if (sum[27]) begin
         norm   = {sum[27:2], sum[1] | sum[0]};
         e_norm = $signed({2'b00, ex}) + 10'sd1;
      end else begin
         norm   = sum[26:0] << lz;
         e_norm = $signed({2'b00, ex}) - $signed({5'b00000, lz});
      end
   end

   assign inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
   assign rnd   = {1'b0, norm[26:3]} + {24'd0, inc};
   assign mant  = rnd[24] ? rnd[23:1] : rnd[22:0];
   assign e_fin = e_norm + $signed({9'd0, rnd[24]});

   always_comb begin
      res_o   = '0;
      flags_o = 4'b0000;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         res_o   = 32'h7FC0_0000;
         flags_o = 4'b0010;
      end else if (a_inf) begin
         res_o = {sa, 8'hFF, 23'd0};
      end else if (b_inf) begin
         res_o = {sb, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         res_o   = {sa & sb, 31'd0};
         flags_o = 4'b0001;
      end else if (sum == '0) begin
         flags_o = 4'b0001;
      end else if (e_fin >= 10'sd255) begin
         res_o   = {sx, 8'hFF, 23'd0};
         flags_o = 4'b1000;
      end else if (e_fin <= 10'sd0) begin
         res_o   = {sx, 31'd0};
         flags_o = 4'b0101;
      end else begin
         res_o = {sx, e_fin[7:0], mant};
      end
   end
endmodule

module fp_addsub_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_opd1_0,
   input  logic [DATA_W-1:0] req_opd2_0,
   input  logic [DATA_W-1:0] req_opd1_1,
   input  logic [DATA_W-1:0] req_opd2_1,
   input  logic [1:0]        req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_res,
   output logic [3:0]        rsp_flags,
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, grant_id, accept;
   logic [DATA_W-1:0] opd1_q, opd2_q, rsp_res_q, fu_res;
   logic              op_q, id_q, rsp_id_q;
   logic [3:0]        rsp_flags_q, fu_flags;
   logic [CNT_W-1:0]  ops_done_q, ops_done_d;

   // On a tie the requester not granted last wins; a lone requester always wins.
   assign grant_id = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
   assign accept   = (state_q == IDLE) && (req_valid != 2'b00);

   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      case (state_q)
         IDLE: if (req_valid != 2'b00) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
            state_d   = EXEC;
         end
         EXEC:    state_d = DONE;
         DONE:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ops_done_d = (state_q == DONE && rsp_ready && ops_done_q != '1)
                       ? ops_done_q + CNT_W'(1) : ops_done_q;

   fp_add_sub #(.DATA_W(DATA_W)) u_fp (
      .opd1_i  (opd1_q),
      .opd2_i  (opd2_q),
      .op_i    (op_q),
      .res_o   (fu_res),
      .flags_o (fu_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         opd1_q       <= '0;
         opd2_q       <= '0;
         op_q         <= 1'b0;
         id_q         <= 1'b0;
         rsp_res_q    <= '0;
         rsp_flags_q  <= '0;
         rsp_id_q     <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         ops_done_q <= ops_done_d;
         if (accept) begin
            opd1_q       <= grant_id ? req_opd1_1 : req_opd1_0;
            opd2_q       <= grant_id ? req_opd2_1 : req_opd2_0;
            op_q         <= req_op[grant_id];
            id_q         <= grant_id;
            last_grant_q <= grant_id;
         end
         if (state_q == EXEC) begin
            rsp_res_q   <= fu_res;
            rsp_flags_q <= fu_flags;
            rsp_id_q    <= id_q;
         end
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign rsp_res   = rsp_res_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_id    = rsp_id_q;
   assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench: a real-arithmetic transaction model checked every cycle, plus directed
// vectors with hand-computed results, round-robin order, hold, saturation and reset-in-flight.

module tb_fp_addsub_arbiter;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       req_valid = 2'b00;
   logic [1:0]       req_ready;
   logic [31:0]      req_opd1_0 = '0, req_opd2_0 = '0, req_opd1_1 = '0, req_opd2_1 = '0;
   logic [1:0]       req_op = 2'b00;
   logic             rsp_valid, rsp_id, busy;
   logic             rsp_ready = 1'b1;
   logic [31:0]      rsp_res;
   logic [3:0]       rsp_flags;
   logic [CNT_W-1:0] ops_done;

   fp_addsub_arbiter #(.DATA_W(32), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_opd1_0(req_opd1_0), .req_opd2_0(req_opd2_0),
      .req_opd1_1(req_opd1_1), .req_opd2_1(req_opd2_1),
      .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
      .busy(busy), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_err++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // ---------------- reference model: IEEE-754 via real arithmetic ----------------
   function automatic real pow2(input int e);
      real p = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
      else        for (int i = 0; i < -e; i++) p = p / 2.0;
      return p;
   endfunction

   function automatic real fp_to_real(input logic [31:0] x);
      real v;
      if (x[30:23] == 8'h00) return 0.0;
      v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
      return x[31] ? -v : v;
   endfunction

   // Returns {flags, result}.
   function automatic logic [35:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
      logic [31:0] bb;
      logic        an, bn, ai, bi, s;
      real         r, mag, f;
      int          e, m;
      bb = {b[31] ^ op, b[30:0]};
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
      if (an || bn || (ai && bi && a[31] != bb[31])) return {4'b0010, 32'h7FC0_0000};
      if (ai) return {4'b0000, a[31], 8'hFF, 23'd0};
      if (bi) return {4'b0000, bb[31], 8'hFF, 23'd0};
      r = fp_to_real(a) + fp_to_real(bb);
      if (r == 0.0) begin
         s = (a[30:23] == 0 && bb[30:23] == 0) ? (a[31] & bb[31]) : 1'b0;
         return {4'b0001, s, 31'd0};
      end
      s = (r < 0.0);
      mag = s ? -r : r;
      e = 0;
      while (mag >= 2.0) begin mag = mag / 2.0; e++; end
      while (mag < 1.0)  begin mag = mag * 2.0; e--; end
      f = (mag - 1.0) * 8388608.0;
      m = $rtoi(f);
      if ((f - m) > 0.5 || ((f - m) == 0.5 && (m % 2) == 1)) m++;
      if (m == 8388608) begin m = 0; e++; end
      if (e + 127 >= 255) return {4'b1000, s, 8'hFF, 23'd0};
      if (e + 127 <= 0)   return {4'b0101, s, 31'd0};
      return {4'b0000, s, 8'(e + 127), 23'(m)};
   endfunction

   // Transaction-level model: 0 = free, 1 = computing, 2 = result offered.
   int          m_phase = 0;
   logic        m_last = 1'b1;
   int          m_ops = 0;
   logic [35:0] m_rsp = '0;
   logic        m_id = 1'b0;
   logic        m_g;
   logic [1:0]  m_ready;

   always @(negedge clk) begin
      if (rst) begin
         m_phase = 0; m_last = 1'b1; m_ops = 0; m_rsp = '0; m_id = 1'b0;
      end
      if (req_valid[0] && (!req_valid[1] || m_last == 1'b1)) m_g = 1'b0;
      else m_g = 1'b1;
      m_ready = (m_phase == 0 && req_valid != 2'b00) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      check("cyc_req_ready", req_ready, m_ready);
      check("cyc_rsp_valid", rsp_valid, m_phase == 2);
      check("cyc_busy", busy, m_phase != 0);
      check("cyc_ops_done", ops_done, m_ops);
      if (m_phase == 2) begin
         check("cyc_rsp_res", rsp_res, m_rsp[31:0]);
         check("cyc_rsp_flags", rsp_flags, m_rsp[35:32]);
         check("cyc_rsp_id", rsp_id, m_id);
      end
      if (!rst) begin
         case (m_phase)
            0: if (req_valid != 2'b00) begin
                  m_rsp = m_g ? fp_model(req_opd1_1, req_opd2_1, req_op[1])
                              : fp_model(req_opd1_0, req_opd2_0, req_op[0]);
                  m_id = m_g; m_last = m_g; m_phase = 1;
               end
            1: m_phase = 2;
            default: if (rsp_ready) begin
                  m_phase = 0;
                  if (m_ops < (1 << CNT_W) - 1) m_ops++;
               end
         endcase
      end
   end

   // Accept log: cycle number and requester of every request handshake.
   int acc_cyc[$];
   int acc_id[$];
   always @(negedge clk) begin
      if (!rst && (req_valid & req_ready) != 2'b00) begin
         acc_cyc.push_back(cyc);
         acc_id.push_back(int'(req_ready[1]));
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        id;
      logic [31:0] a, b;
      logic        op;
      logic [31:0] res;
      logic [3:0]  flags;
      int          hold;
   } vec_t;
   vec_t vecs[$];
   int   exp_ops = 0;

   task automatic apply_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_op(input vec_t v);
      int k;
      check("model_pin", fp_model(v.a, v.b, v.op), {v.flags, v.res});
      if (v.id) begin req_opd1_1 = v.a; req_opd2_1 = v.b; end
      else      begin req_opd1_0 = v.a; req_opd2_0 = v.b; end
      req_op[v.id]    = v.op;
      req_valid[v.id] = 1'b1;
      rsp_ready       = (v.hold == 0);
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready[v.id]) break;
      end
      if (k == 20) timeout_fail("accept_wait");
      @(posedge clk);
      #1 req_valid = 2'b00;
      for (k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      if (k == 5) timeout_fail("rsp_wait");
      check("vec_res", rsp_res, v.res);
      check("vec_flags", rsp_flags, v.flags);
      check("vec_id", rsp_id, v.id);
      if (v.hold > 0) begin
         req_valid = 2'b11;
         repeat (v.hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_ready", req_ready, 2'b00);
            check("hold_res", rsp_res, v.res);
            check("hold_ops", ops_done, exp_ops);
         end
         req_valid = 2'b00;
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      if (exp_ops < (1 << CNT_W) - 1) exp_ops++;
      check("vec_ops_done", ops_done, exp_ops);
      check("vec_rsp_dropped", rsp_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0001, 0});
      vecs.push_back('{1'b0, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0010, 5});
      vecs.push_back('{1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b1000, 0});
      vecs.push_back('{1'b0, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0000, 0});
      vecs.push_back('{1'b1, 32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 4'b0000, 0});
      vecs.push_back('{1'b0, 32'h4040_0000, 32'h4020_0000, 1'b1, 32'h3F00_0000, 4'b0000, 0});
      vecs.push_back('{1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 4'b0000, 0});
      vecs.push_back('{1'b0, 32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 4'b0101, 0});
      vecs.push_back('{1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 4'b0000, 0});
      vecs.push_back('{1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b0010, 0});
      vecs.push_back('{1'b1, 32'h3F80_0000, 32'h0D80_0000, 1'b0, 32'h3F80_0000, 4'b0000, 0});
      vecs.push_back('{1'b0, 32'hC0A0_0000, 32'h4040_0000, 1'b0, 32'hC000_0000, 4'b0000, 0});

      // Reset state.
      apply_reset(3);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ops_done", ops_done, 0);
      check("rst_rsp_res", rsp_res, 32'h0);
      check("rst_rsp_flags", rsp_flags, 4'h0);
      check("rst_rsp_id", rsp_id, 1'b0);
      check("rst_req_ready", req_ready, 2'b00);

      // 1.0 + 2.0 from requester 0, accepted on the first edge after reset.
      req_opd1_0 = 32'h3F80_0000; req_opd2_0 = 32'h4000_0000; req_op = 2'b00;
      req_valid  = 2'b01;
      #1 check("first_ready", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = 2'b00;
      check("first_exec_valid", rsp_valid, 1'b0);
      check("first_exec_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      check("first_valid", rsp_valid, 1'b1);
      check("first_res", rsp_res, 32'h4040_0000);
      check("first_flags", rsp_flags, 4'b0000);
      check("first_id", rsp_id, 1'b0);
      @(posedge clk);
      #1;
      check("first_ops_done", ops_done, 1);
      exp_ops = 1;

      foreach (vecs[i]) do_op(vecs[i]);
      check("ops_saturated", ops_done, (1 << CNT_W) - 1);

      // Both requesters valid straight out of reset.
      req_opd1_0 = 32'h3F80_0000; req_opd2_0 = 32'h4000_0000;
      req_opd1_1 = 32'h4040_0000; req_opd2_1 = 32'h3F80_0000; req_op = 2'b10;
      rsp_ready  = 1'b1;
      req_valid  = 2'b11;
      apply_reset(3);
      acc_cyc.delete();
      acc_id.delete();
      begin
         int t0;
         t0 = cyc;
         repeat (12) @(posedge clk);
         #1 req_valid = 2'b00;
         repeat (4) @(posedge clk);
         #1;
         check("rr_accepts", acc_id.size() >= 4, 1'b1);
         if (acc_id.size() >= 4) begin
            check("rr_first_edge", acc_cyc[0], t0);
            for (int i = 0; i < 4; i++) check("rr_grant", acc_id[i], i % 2);
            for (int i = 1; i < 4; i++) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
         end
      end

      // Reset while an operation is executing.
      req_opd1_0 = 32'h3F80_0000; req_opd2_0 = 32'h3F80_0000; req_op = 2'b00;
      req_valid  = 2'b01;
      @(posedge clk);
      #1 check("rstx_busy_before", busy, 1'b1);
      rst = 1'b1;
      req_valid = 2'b00;
      #1;
      check("rstx_busy", busy, 1'b0);
      check("rstx_valid", rsp_valid, 1'b0);
      check("rstx_ops", ops_done, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("rstx_no_stale", rsp_valid, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
